// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode/execute hazard controller.
package hazard_pkg;

   localparam int NREGS  = 8;
   localparam int REG_W  = 3;
   localparam int CNT_W  = 2;
   localparam int PERF_W = 16;

   localparam logic [3:0] HALT_OPC = 4'b0000;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: counts in-flight writes to a single architectural register.
module sb_entry
   import hazard_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic ret,
   output logic busy,
   output logic full,
   output logic underflow,
   output logic next_zero
);

   logic [W-1:0] count;
   logic [W-1:0] count_nxt;

   assign busy      = (count != '0);
   assign full      = (count == '1);
   assign underflow = ret & ~busy;

   // A retire only counts when something is outstanding; issue+retire cancel.
   always_comb begin
      count_nxt = count;
      if (inc & ~(ret & busy))
         count_nxt = count + 1'b1;
      else if (~inc & ret & busy)
         count_nxt = count - 1'b1;
   end

   assign next_zero = (count_nxt == '0);

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard issue controller: RAW/WAW stalls, branch kill, halt drain and stall perf counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NREGS  = hazard_pkg::NREGS,
   parameter int REG_W  = hazard_pkg::REG_W,
   parameter int CNT_W  = hazard_pkg::CNT_W,
   parameter int PERF_W = hazard_pkg::PERF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [REG_W-1:0]  dec_rq,
   input  logic [REG_W-1:0]  dec_rs,
   input  logic              dec_use_rq,
   input  logic              dec_use_rs,
   input  logic              dec_wr_en,
   input  logic [REG_W-1:0]  dec_wr_reg,
   input  logic              dec_halt,
   input  logic              ex_br_taken,
   input  logic              wb_en,
   input  logic [REG_W-1:0]  wb_reg,
   output logic              issue,
   output logic              stall,
   output logic              kill,
   output logic              halted,
   output logic [NREGS-1:0]  busy_mask,
   output logic [PERF_W-1:0] stall_cnt,
   output logic              sb_err,
   output state_t            dbg_state
);

   state_t           state;
   state_t           state_nxt;
   logic [NREGS-1:0] full_mask;
   logic [NREGS-1:0] uf_mask;
   logic [NREGS-1:0] zero_mask;
   logic             wr_req;
   logic             hz;
   logic             ov;
   logic             run;

   // Halt never writes a register, whatever the write-enable field says.
   assign wr_req = dec_wr_en & ~dec_halt;

   for (genvar i = 0; i < NREGS; i++) begin : g_sb
      sb_entry #(.W(CNT_W)) u_entry (
         .clk       (clk),
         .rst       (rst),
         .inc       (issue & wr_req & (dec_wr_reg == REG_W'(i))),
         .ret       (wb_en & (wb_reg == REG_W'(i))),
         .busy      (busy_mask[i]),
         .full      (full_mask[i]),
         .underflow (uf_mask[i]),
         .next_zero (zero_mask[i])
      );
   end

   // Hazards look only at registered counts: no writeback bypass.
   assign hz  = (dec_use_rq & busy_mask[dec_rq]) | (dec_use_rs & busy_mask[dec_rs]);
   assign ov  = wr_req & full_mask[dec_wr_reg];
   assign run = (state == RUN);

   assign issue = run & dec_valid & ~ex_br_taken & ~hz & ~ov;
   assign stall = ~run | (dec_valid & ~ex_br_taken & (hz | ov));
   assign kill  = dec_valid & ~issue;

   always_ff @(posedge clk) begin
      if (!rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (issue & dec_halt) state_nxt = DRAIN;
         DRAIN:   if (&zero_mask)       state_nxt = HALTED;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      halted    = (state == HALTED);
      dbg_state = state;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         sb_err    <= 1'b0;
      end else begin
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (|uf_mask)
            sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic [2:0]  dec_rq;
   logic [2:0]  dec_rs;
   logic        dec_use_rq;
   logic        dec_use_rs;
   logic        dec_wr_en;
   logic [2:0]  dec_wr_reg;
   logic        dec_halt;
   logic        ex_br_taken;
   logic        wb_en;
   logic [2:0]  wb_reg;
   logic        issue;
   logic        stall;
   logic        kill;
   logic        halted;
   logic [7:0]  busy_mask;
   logic [15:0] stall_cnt;
   logic        sb_err;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;
   int exp_sc = 0;

   hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .dec_valid   (dec_valid),
      .dec_rq      (dec_rq),
      .dec_rs      (dec_rs),
      .dec_use_rq  (dec_use_rq),
      .dec_use_rs  (dec_use_rs),
      .dec_wr_en   (dec_wr_en),
      .dec_wr_reg  (dec_wr_reg),
      .dec_halt    (dec_halt),
      .ex_br_taken (ex_br_taken),
      .wb_en       (wb_en),
      .wb_reg      (wb_reg),
      .issue       (issue),
      .stall       (stall),
      .kill        (kill),
      .halted      (halted),
      .busy_mask   (busy_mask),
      .stall_cnt   (stall_cnt),
      .sb_err      (sb_err),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      dec_valid   = 1'b0;
      dec_rq      = '0;
      dec_rs      = '0;
      dec_use_rq  = 1'b0;
      dec_use_rs  = 1'b0;
      dec_wr_en   = 1'b0;
      dec_wr_reg  = '0;
      dec_halt    = 1'b0;
      ex_br_taken = 1'b0;
      wb_en       = 1'b0;
      wb_reg      = '0;
   endtask

   task automatic dec_write(input logic [2:0] r);
      idle();
      dec_valid  = 1'b1;
      dec_wr_en  = 1'b1;
      dec_wr_reg = r;
   endtask

   task automatic retire(input logic [2:0] r);
      wb_en  = 1'b1;
      wb_reg = r;
   endtask

   // Check the combinational outputs for the current inputs, then clock once.
   task automatic cyc(input string tag, input logic ei, input logic es, input logic ek);
      #1;
      check({tag, ".issue"}, 32'(issue), 32'(ei));
      check({tag, ".stall"}, 32'(stall), 32'(es));
      check({tag, ".kill"},  32'(kill),  32'(ek));
      if (es) exp_sc++;
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b0;
      tick();
      check("rst.halted_during", 32'(halted), 32'd0);
      tick();
      rst = 1'b1;
      check("rst.busy",   32'(busy_mask), 32'h00);
      check("rst.halted", 32'(halted),    32'd0);
      check("rst.sc",     32'(stall_cnt), 32'd0);
      check("rst.err",    32'(sb_err),    32'd0);
      check("rst.state",  32'(dbg_state), 32'(RUN));

      // RAW on r3 via rq, retire lands while stalled, issue the cycle after.
      dec_write(3'd3);
      cyc("raw.wr", 1, 0, 0);
      check("raw.busy_set", 32'(busy_mask), 32'h08);
      idle(); dec_valid = 1; dec_use_rq = 1; dec_rq = 3'd3;
      cyc("raw.s1", 0, 1, 1);
      cyc("raw.s2", 0, 1, 1);
      cyc("raw.s3", 0, 1, 1);
      check("raw.busy_hold", 32'(busy_mask), 32'h08);
      retire(3'd3);
      cyc("raw.wb", 0, 1, 1);
      check("raw.busy_clr", 32'(busy_mask), 32'h00);
      idle(); dec_valid = 1; dec_use_rq = 1; dec_rq = 3'd3;
      cyc("raw.go", 1, 0, 0);
      check("raw.sc", 32'(stall_cnt), 32'(exp_sc));

      // Simultaneous issue and retire on r5 leaves count at 1.
      dec_write(3'd5);
      cyc("sim.wr", 1, 0, 0);
      dec_write(3'd5); retire(3'd5);
      cyc("sim.both", 1, 0, 0);
      check("sim.busy", 32'(busy_mask), 32'h20);
      idle(); retire(3'd5);
      cyc("sim.ret", 0, 0, 0);
      check("sim.busy_clr", 32'(busy_mask), 32'h00);

      // WAW saturation on r2.
      for (int i = 0; i < 3; i++) begin
         dec_write(3'd2);
         cyc("waw.fill", 1, 0, 0);
      end
      check("waw.busy", 32'(busy_mask), 32'h04);
      dec_write(3'd2);
      cyc("waw.full", 0, 1, 1);
      dec_write(3'd2); retire(3'd2);
      cyc("waw.wb", 0, 1, 1);
      dec_write(3'd2);
      cyc("waw.go", 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle(); retire(3'd2);
         cyc("waw.drain", 0, 0, 0);
      end
      check("waw.busy_clr", 32'(busy_mask), 32'h00);
      check("waw.sc", 32'(stall_cnt), 32'(exp_sc));

      // Branch kill beats a RAW hazard on r4 via rs.
      dec_write(3'd4);
      cyc("br.wr", 1, 0, 0);
      idle(); dec_valid = 1; dec_use_rs = 1; dec_rs = 3'd4; ex_br_taken = 1;
      cyc("br.kill", 0, 0, 1);
      check("br.busy", 32'(busy_mask), 32'h10);
      idle(); retire(3'd4);
      cyc("br.ret", 0, 0, 0);
      check("br.busy_clr", 32'(busy_mask), 32'h00);

      // Halt drain: r1 and r6 pending; halt carries a stray write-enable to r1.
      dec_write(3'd1);
      cyc("halt.w1", 1, 0, 0);
      dec_write(3'd6);
      cyc("halt.w6", 1, 0, 0);
      check("halt.busy", 32'(busy_mask), 32'h42);
      dec_write(3'd1); dec_halt = 1;
      cyc("halt.issue", 1, 0, 0);
      check("halt.state_drain", 32'(dbg_state), 32'(DRAIN));
      check("halt.busy_nowr", 32'(busy_mask), 32'h42);
      idle(); retire(3'd1);
      cyc("halt.d1", 0, 1, 0);
      idle();
      cyc("halt.d2", 0, 1, 0);
      check("halt.not_yet", 32'(halted), 32'd0);
      retire(3'd6);
      cyc("halt.d3", 0, 1, 0);
      check("halt.halted", 32'(halted), 32'd1);
      check("halt.state", 32'(dbg_state), 32'(HALTED));
      idle(); dec_valid = 1;
      cyc("halt.parked", 0, 1, 1);
      check("halt.sc", 32'(stall_cnt), 32'(exp_sc));

      // Underflow while halted, then reset.
      idle(); retire(3'd0);
      cyc("uf.wb", 0, 1, 0);
      check("uf.err", 32'(sb_err), 32'd1);
      idle();
      cyc("uf.hold", 0, 1, 0);
      check("uf.err_sticky", 32'(sb_err), 32'd1);
      check("uf.sc", 32'(stall_cnt), 32'(exp_sc));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("rst2.halted", 32'(halted),    32'd0);
      check("rst2.busy",   32'(busy_mask), 32'h00);
      check("rst2.sc",     32'(stall_cnt), 32'd0);
      check("rst2.err",    32'(sb_err),    32'd0);
      check("rst2.state",  32'(dbg_state), 32'(RUN));
      dec_write(3'd7);
      cyc("rst2.issue", 1, 0, 0);
      check("rst2.busy7", 32'(busy_mask), 32'h80);
      check("rst2.sc_after", 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
